uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Sits between the UART receiver and the render/geometry stage.
- Consumes received bytes (data plus one-cycle done tick) and assembles fixed 5-byte framed packets.
- Checks each packet's checksum and writes validated 16-bit words into an internal parameter register file. The file holds object position, vertex coordinates and colour.
- Downstream rendering logic reads the file combinationally and receives a commit strobe for frame-synchronous updates.

Parameters:
- NUM_REGS, 16, number of 16-bit parameter registers (2..255).
- SYNC_BYTE, 8'hA5, packet start marker.
- COMMIT_ADDR, 8'hFF, address byte that means "commit" instead of a register write.
- TIMEOUT_CYCLES, 65535, maximum idle clocks between bytes of one packet; range 1..65535.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- rx_data, input, 8, received byte; valid only while rx_done_tick is high.
- rx_done_tick, input, 1, one-cycle strobe marking a new byte.
- rd_addr, input, 8, register-file read address.
- rd_data, output, 16, combinational read of reg[rd_addr]; 0 if rd_addr >= NUM_REGS.
- reg_wr_stb, output, 1, one-cycle pulse on each validated register write.
- reg_wr_addr, output, 8, address of the last write.
- reg_wr_data, output, 16, data of the last write.
- commit_stb, output, 1, one-cycle pulse on a validated commit packet.
- err_count, output, 8, saturating count of rejected packets.
- busy, output, 1, high whenever FSM is not in IDLE.

Behaviour:
- Reset is asynchronous on rst_n low. All of the following go to 0: register-file contents, reg_wr_stb, reg_wr_addr, reg_wr_data, commit_stb, err_count, timeout counter. FSM goes to IDLE.
- Packet format: SYNC, ADDR, DHI, DLO, CHK. CHK = ADDR ^ DHI ^ DLO; SYNC is excluded.
- FSM states: IDLE, GET_ADDR, GET_HI, GET_LO, GET_CHK.
  - States advance only on cycles with rx_done_tick = 1.
  - IDLE: a tick with rx_data == SYNC_BYTE -> GET_ADDR. Any other byte is silently discarded and is not an error.
  - GET_ADDR -> GET_HI -> GET_LO -> GET_CHK, latching each byte.
  - SYNC_BYTE received inside a packet is treated as data, not as a resync.
  - GET_CHK tick always returns to IDLE.
- Checksum validation on the GET_CHK tick (edge E = first clock edge sampling that tick):
  - Checksum matches and ADDR < NUM_REGS: reg[ADDR] <= {DHI,DLO}, reg_wr_addr/reg_wr_data updated, reg_wr_stb = 1. All take effect at E; stb is high for exactly the one cycle following E.
  - Checksum matches and ADDR == COMMIT_ADDR: commit_stb = 1 for one cycle after E. No register write; reg_wr_addr/reg_wr_data unchanged.
  - Checksum mismatch, or valid checksum with any other ADDR: no write, no strobe, err_count increments.
  - Latency: 1 clock from the CHK tick to strobe/visible rd_data.
- Timeout:
  - Counter clears on every tick and on entering IDLE; it counts each non-tick cycle while in a non-IDLE state.
  - When the counter reaches TIMEOUT_CYCLES: FSM -> IDLE, err_count increments, partial packet discarded.
  - If a tick and timeout expiry coincide, the tick wins: the byte is processed and the counter is cleared.
- err_count saturates at 8'hFF and never wraps.
- A strobe and err_count never change in the same cycle, since they are mutually exclusive per packet.
- Back-to-back packets with zero gap are accepted. A SYNC byte arriving one cycle after a CHK tick starts a new packet.
- If rst_n is asserted mid-packet, the partial packet is lost and no strobe is generated.

Test Plan:
- Write: bytes A5,03,01,40,42 -> reg_wr_stb pulses once, reg_wr_addr = 03, reg_wr_data = 0x0140; rd_addr = 3 then reads 0x0140; err_count = 0.
- Commit: A5,FF,00,00,FF -> commit_stb pulses once; reg_wr_stb stays 0; registers unchanged.
- Bad checksum / bad address:
  - A5,03,12,34,00 -> no write, err_count = 1.
  - A5,20,00,00,20 with NUM_REGS = 16 -> no write, err_count = 2.
- Timeout: A5,05 then no tick for TIMEOUT_CYCLES (set to 100) -> busy drops, err_count = 1. Then A5,05,00,07,02 -> reg[5] = 0x0007.
- Noise and in-packet SYNC:
  - Bytes 77,73 in IDLE -> ignored, err_count = 0.
  - A5,01,A5,A5,01 -> reg[1] = 0xA5A5.
  - A tick landing on the exact timeout-expiry cycle is processed normally.
- Reset and saturation:
  - rst_n low during GET_LO -> all outputs 0, no strobe afterwards.
  - 300 bad packets -> err_count = 0xFF.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles checksummed 5-byte UART packets into parameter register writes and commit strobes
module uart_cmd_decoder #(
  parameter int NUM_REGS = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] COMMIT_ADDR = 8'hFF,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done_tick,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        reg_wr_stb,
  output logic [7:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        commit_stb,
  output logic [7:0]  err_count,
  output logic        busy
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [8:0] NREGS = 9'(NUM_REGS);
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_HI, GET_LO, GET_CHK} state_t;
  state_t state, next_state;
  logic [7:0] addr_q, hi_q, lo_q;
  logic [15:0] tmo_cnt;
  logic [15:0] regs [NUM_REGS];
  logic chk_tick, chk_ok, addr_ok, wr_en, cm_en, timeout, err_en;
  assign chk_tick = rx_done_tick && state == GET_CHK;
  assign chk_ok = (addr_q ^ hi_q ^ lo_q) == rx_data;
  assign addr_ok = {1'b0, addr_q} < NREGS;
  assign wr_en = chk_tick && chk_ok && addr_ok;
  assign cm_en = chk_tick && chk_ok && addr_q == COMMIT_ADDR;
  // expiry fires on the idle cycle that would bring the gap to TIMEOUT_CYCLES; a tick there wins
  assign timeout = !rx_done_tick && state != IDLE && tmo_cnt == TMAX;
  assign err_en = timeout || (chk_tick && !wr_en && !cm_en);
  assign busy = state != IDLE;
  assign rd_data = {1'b0, rd_addr} < NREGS ? regs[rd_addr[AW-1:0]] : 16'h0;
  always_comb begin
    next_state = state;
    if (rx_done_tick)
      case (state)
        IDLE:     next_state = rx_data == SYNC_BYTE ? GET_ADDR : IDLE;
        GET_ADDR: next_state = GET_HI;
        GET_HI:   next_state = GET_LO;
        GET_LO:   next_state = GET_CHK;
        default:  next_state = IDLE;
      endcase
    else if (timeout)
      next_state = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      tmo_cnt <= '0;
      reg_wr_stb <= 1'b0;
      commit_stb <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      err_count <= '0;
    end else begin
      reg_wr_stb <= wr_en;
      commit_stb <= cm_en;
      tmo_cnt <= (rx_done_tick || next_state == IDLE) ? '0 : tmo_cnt + 16'd1;
      if (rx_done_tick && state == GET_ADDR) addr_q <= rx_data;
      if (rx_done_tick && state == GET_HI) hi_q <= rx_data;
      if (rx_done_tick && state == GET_LO) lo_q <= rx_data;
      if (wr_en) begin
        reg_wr_addr <= addr_q;
        reg_wr_data <= {hi_q, lo_q};
      end
      if (err_en && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (wr_en) regs[addr_q[AW-1:0]] <= {hi_q, lo_q};
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: randomized packet stream checked against a packet-level reference model
module tb_uart_cmd_decoder;
  localparam int TMO = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_done_tick = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic reg_wr_stb;
  logic [7:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic commit_stb;
  logic [7:0] err_count;
  logic busy;
  int vecs = 0;
  int errs = 0;
  logic [15:0] m_regs [16];
  int m_err = 0;
  logic [7:0] m_wa = '0;
  logic [15:0] m_wd = '0;

  uart_cmd_decoder #(.NUM_REGS(16), .SYNC_BYTE(8'hA5), .COMMIT_ADDR(8'hFF), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .commit_stb(commit_stb), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int outcome(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] c);
    if ((a ^ hi ^ lo) !== c) return 2;
    if (a < 8'd16) return 0;
    if (a == 8'hFF) return 1;
    return 2;
  endfunction

  function automatic void model_err();
    m_err = m_err == 255 ? 255 : m_err + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_err = 0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic step(input bit t, input logic [7:0] d, input bit ew, input bit ec);
    rx_done_tick = t;
    rx_data = d;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rx_data = 8'($urandom);
    vecs++;
    if (reg_wr_stb !== ew || commit_stb !== ec) begin
      errs++;
      $display("FAIL strobe t=%0t wr=%b exp %b commit=%b exp %b", $time, reg_wr_stb, ew, commit_stb, ec);
    end
    vecs++;
    if (err_count !== 8'(m_err)) begin
      errs++;
      $display("FAIL err_count t=%0t got %h exp %h", $time, err_count, 8'(m_err));
    end
  endtask

  task automatic apply_pkt(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] c, input int gap);
    logic [7:0] b [5];
    int o;
    b = '{8'hA5, a, hi, lo, c};
    o = outcome(a, hi, lo, c);
    for (int i = 0; i < 5; i++) begin
      repeat (gap) step(1'b0, 8'($urandom), 1'b0, 1'b0);
      if (i < 4) step(1'b1, b[i], 1'b0, 1'b0);
      else begin
        if (o == 0) begin
          m_regs[a[3:0]] = {hi, lo};
          m_wa = a;
          m_wd = {hi, lo};
        end
        if (o == 2) model_err();
        step(1'b1, b[4], o == 0, o == 1);
      end
    end
    vecs++;
    if (reg_wr_addr !== m_wa || reg_wr_data !== m_wd || busy !== 1'b0) begin
      errs++;
      $display("FAIL last_write addr=%h exp %h data=%h exp %h busy=%b exp 0", reg_wr_addr, m_wa, reg_wr_data, m_wd, busy);
    end
  endtask

  task automatic check_regs();
    for (int a = 0; a < 20; a++) begin
      rd_addr = 8'(a);
      @(negedge clk);
      vecs++;
      if (rd_data !== (a < 16 ? m_regs[a] : 16'h0)) begin
        errs++;
        $display("FAIL rd_data addr=%0d got %h exp %h", a, rd_data, a < 16 ? m_regs[a] : 16'h0);
      end
    end
  endtask

  task automatic check_rd(input logic [7:0] a, input logic [15:0] exp);
    rd_addr = a;
    @(negedge clk);
    vecs++;
    if (rd_data !== exp) begin
      errs++;
      $display("FAIL rd_const addr=%h got %h exp %h", a, rd_data, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    vecs++;
    if (reg_wr_stb !== 1'b0 || commit_stb !== 1'b0 || err_count !== 8'h0 || reg_wr_addr !== 8'h0 || reg_wr_data !== 16'h0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s outputs stb=%b cm=%b err=%h wa=%h wd=%h busy=%b exp all 0", tag, reg_wr_stb, commit_stb, err_count, reg_wr_addr, reg_wr_data, busy);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check_regs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    apply_pkt(8'h03, 8'h01, 8'h40, 8'h42, 0);
    check_rd(8'h03, 16'h0140);
    check_regs();
  endtask

  task automatic test_commit();
    apply_pkt(8'hFF, 8'h00, 8'h00, 8'hFF, 0);
    check_regs();
  endtask

  task automatic test_errors();
    apply_pkt(8'h03, 8'h12, 8'h34, 8'h00, 1);
    apply_pkt(8'h20, 8'h00, 8'h00, 8'h20, 0);
    check_regs();
  endtask

  task automatic test_noise_sync();
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h73, 1'b0, 1'b0);
    apply_pkt(8'h01, 8'hA5, 8'hA5, 8'h01, 0);
    check_rd(8'h01, 16'hA5A5);
  endtask

  task automatic test_timeout();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    repeat (TMO - 1) step(1'b0, 8'($urandom), 1'b0, 1'b0);
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL timeout_early busy=%b exp 1", busy);
    end
    model_err();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL timeout_busy busy=%b exp 0", busy);
    end
    apply_pkt(8'h05, 8'h00, 8'h07, 8'h02, 0);
    check_rd(8'h05, 16'h0007);
  endtask

  task automatic test_expiry_tick();
    apply_pkt(8'h06, 8'h12, 8'h34, 8'h06 ^ 8'h12 ^ 8'h34, TMO - 1);
    check_regs();
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 60; p++) begin
      int kind;
      logic [7:0] a, hi, lo, c, n;
      kind = $urandom_range(0, 3);
      hi = 8'($urandom);
      lo = 8'($urandom);
      a = kind == 0 ? 8'($urandom_range(0, 15)) : kind == 1 ? 8'hFF : 8'($urandom_range(16, 254));
      c = a ^ hi ^ lo;
      if (kind == 2) c = c ^ 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) begin
        n = 8'($urandom);
        if (n == 8'hA5) n = 8'h00;
        step(1'b1, n, 1'b0, 1'b0);
      end
      apply_pkt(a, hi, lo, c, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    end
    check_regs();
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h03 ^ 8'h11 ^ 8'h22, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    check_regs();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) apply_pkt(8'h20, 8'h00, 8'h00, 8'h21, 0);
    vecs++;
    if (err_count !== 8'hFF) begin
      errs++;
      $display("FAIL saturation err_count=%h exp ff", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_commit();
    test_errors();
    test_noise_sync();
    test_timeout();
    test_expiry_tick();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
